icache_nway: RTL
================

Name: icache_nway

Overview:
- Parametrised N-way set-associative, read-only instruction cache with multi-word lines.
- Sits between the IF stage (inst_* side) and the memory/AXI bridge (cache_* side).
- Extends the two-way, single-word instruction cache with:
  - configurable ways, sets and line length
  - round-robin replacement with invalid-way-first
  - sequential line refill
  - fence.i invalidation with a completion pulse.

Parameters:
ADDR_W, 64, fetch address width
INST_W, 32, instruction/word width (fixed at 32; memory returns one word per beat)
WAYS, 2, associativity; power of 2, 1..8
SETS, 64, sets per way; power of 2, 2..256
LINE_WORDS, 2, 32-bit words per line; power of 2, 1..16

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
inst_ena  input  1  fetch request; qualified by inst_ready
inst_addr  input  ADDR_W  fetch address; bits [1:0] ignored
inst_ready  output  1  cache accepts a request this cycle
inst_data  output  32  fetched instruction, valid with inst_valid
inst_valid  output  1  one-cycle response pulse
fence_i  input  1  invalidate-all request (level)
flush_done  output  1  one-cycle pulse, last set invalidated
cache_read_ena  output  1  word read request to memory
cache_addr  output  ADDR_W  word-aligned read address
cache_or_data  input  32  read data
cache_in_ok  input  1  read data valid (one-cycle pulse per word)

Behaviour:
- Reset:
  - rst is asynchronous and active-low: rst=0 forces reset immediately, independent of clk.
  - While rst=0: FSM=IDLE; all valid bits 0; round-robin pointers 0; refill counter 0.
  - Output values in reset: inst_valid=0, inst_data=0, cache_read_ena=0, cache_addr=0, flush_done=0.
  - Tag/data arrays are not reset.
- Address split: OFF=log2(LINE_WORDS); SI=log2(SETS).
  - word index = addr[2+OFF-1:2]
  - set index = addr[2+OFF+SI-1:2+OFF]
  - tag = addr[ADDR_W-1:2+OFF+SI]
- FSM states: IDLE, LOOKUP, REFILL, RESPOND, FLUSH.
- inst_ready = (state==IDLE) && !fence_i.
- IDLE:
  - fence_i=1 -> FLUSH; fence_i has priority over inst_ena.
  - Else inst_ena=1 -> latch addr, go to LOOKUP; arrays are read with the latched set index.
- LOOKUP: compare all WAYS tags with valid.
  - Hit -> RESPOND, data from the hit way.
  - Miss -> pick victim: lowest-index invalid way, else rr_ptr[set]. Go to REFILL with refill counter=0.
- REFILL:
  - cache_read_ena=1, cache_addr={line base, counter, 2'b00}.
  - Address is held stable until cache_in_ok.
  - On cache_in_ok: write cache_or_data into victim word [counter]; capture it if counter == requested word index; counter++.
  - After word LINE_WORDS-1:
    - write tag and set valid
    - rr_ptr[set] = (victim+1) mod WAYS
    - cache_read_ena drops the same cycle
    - go to RESPOND.
  - Refill always starts at word 0 (no critical-word-first).
- RESPOND: inst_valid=1 for exactly one cycle, inst_data = captured word; next state IDLE.
  - inst_data holds its value until the next response; it is 0 after reset.
- Latency:
  - Hit: accept at T -> inst_valid at T+2.
  - Miss: T+2+sum of the memory wait cycles for all words.
- cache_in_ok outside REFILL is ignored.
- FLUSH:
  - Set counter k runs 0..SETS-1; the valid bits of set k (all ways) clear at cycle k.
  - rr_ptr[k] is reset to 0.
  - flush_done=1 during the k=SETS-1 cycle; then IDLE.
  - The requester deasserts fence_i in the cycle after flush_done; a still-high fence_i in IDLE starts a new flush.
- Reset mid-REFILL or mid-FLUSH: abort immediately.
  - The partially filled line stays invalid.
  - A late cache_in_ok after reset is ignored.
- Hits do not modify replacement state (FIFO-like round-robin).

Test Plan (WAYS=2, SETS=64, LINE_WORDS=2; set=addr[8:3], word=addr[2]):
1. Cold miss and line hit.
   - Stimulus: fetch 0x80000000; memory returns 0x00000013 @0x80000000, then 0x00100093 @0x80000004.
   - Response: two reads in that order; inst_valid with 0x00000013.
   - Then fetch 0x80000004 -> inst_valid at T+2 with 0x00100093, cache_read_ena never asserted.
2. Conflict and replacement.
   - Stimulus: fetch 0x80000000, 0x80000200, 0x80000400 (all set 0).
   - Response: fills go to way0, then way1; the third fill evicts way0.
   - Then 0x80000200 hits (T+2) and 0x80000000 misses (issues a read at 0x80000000).
3. Memory stall.
   - Stimulus: cache_in_ok delayed 5 cycles per word on a miss.
   - Response: cache_read_ena=1 and cache_addr constant through the stall; inst_valid=0 until both words arrive; inst_ready=0 throughout.
4. fence_i.
   - Stimulus: after scenario 1, assert fence_i and inst_ena together in IDLE.
   - Response: inst_ready=0; exactly 64 FLUSH cycles; flush_done a single pulse on the 64th.
   - Then fetch 0x80000004 misses and refills from 0x80000000.
5. Reset mid-refill.
   - Stimulus: pull rst low for 1 cycle after the first word of a miss is accepted.
   - Response: outputs go to reset values immediately; a stray cache_in_ok is ignored.
   - Re-fetch of the same address misses and restarts at the line base.
6. Back-to-back.
   - Stimulus: inst_ena held high with addresses 0x80000000, 0x80000004 (both cached).
   - Response: the second request is accepted only when the FSM returns to IDLE; responses arrive in order, one pulse each, spaced 3 cycles apart.

Source files
------------

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache with multi-word lines.
// Round-robin replacement (invalid way first), sequential refill, fence.i flush.
module icache_nway #(
    parameter int ADDR_W     = 64,
    parameter int INST_W     = 32,
    parameter int WAYS       = 2,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ena,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic              inst_valid,
    input  logic              fence_i,
    output logic              flush_done,
    output logic              cache_read_ena,
    output logic [ADDR_W-1:0] cache_addr,
    input  logic [INST_W-1:0] cache_or_data,
    input  logic              cache_in_ok
);
    localparam int OFF = $clog2(LINE_WORDS);
    localparam int SI  = $clog2(SETS);
    localparam int OW  = (OFF > 0) ? OFF : 1;
    localparam int WW  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TW  = ADDR_W - 2 - OFF - SI;

    typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESPOND, FLUSH} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [OW-1:0]     cnt_q, cnt_d;
    logic [SI-1:0]     fk_q, fk_d;
    logic [WW-1:0]     victim_q, victim_d;
    logic [INST_W-1:0] rdata_q, rdata_d;

    logic [WAYS-1:0]   valid_q [SETS];
    logic [WW-1:0]     rr_q    [SETS];
    logic [TW-1:0]     tag_q   [WAYS][SETS];
    logic [INST_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];

    logic [SI-1:0]     set_idx;
    logic [OW-1:0]     word_idx;
    logic [TW-1:0]     tag_idx;
    logic [ADDR_W-1:0] line_base;
    logic              last_word;
    logic              hit, inv_found;
    logic [WW-1:0]     hit_way, inv_way, victim_sel, rr_next;
    logic              wr_word, fill_done, flush_clr;

    assign set_idx   = SI'(addr_q >> (2 + OFF));
    assign word_idx  = OW'((addr_q >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign tag_idx   = TW'(addr_q >> (2 + OFF + SI));
    assign line_base = addr_q & ~ADDR_W'(LINE_WORDS * 4 - 1);
    assign last_word = (cnt_q == OW'(LINE_WORDS - 1));
    assign rr_next   = WW'((int'(victim_q) + 1) % WAYS);

    // Lowest-index match wins for both the hit way and the free way.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[set_idx][w] && tag_q[w][set_idx] == tag_idx) begin
                hit     = 1'b1;
                hit_way = WW'(w);
            end
            if (!inv_found && !valid_q[set_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
        victim_sel = inv_found ? inv_way : rr_q[set_idx];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fence_i)       state_d = FLUSH;
                else if (inst_ena) state_d = LOOKUP;
            end
            LOOKUP:  state_d = hit ? RESPOND : REFILL;
            REFILL:  if (cache_in_ok && last_word) state_d = RESPOND;
            RESPOND: state_d = IDLE;
            FLUSH:   if (fk_q == SI'(SETS - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        fk_d      = fk_q;
        victim_d  = victim_q;
        rdata_d   = rdata_q;
        wr_word   = 1'b0;
        fill_done = 1'b0;
        flush_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fence_i)       fk_d   = '0;
                else if (inst_ena) addr_d = inst_addr;
            end
            LOOKUP: begin
                victim_d = victim_sel;
                cnt_d    = '0;
                if (hit) rdata_d = data_q[hit_way][set_idx][word_idx];
            end
            REFILL: begin
                if (cache_in_ok) begin
                    wr_word   = 1'b1;
                    fill_done = last_word;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == word_idx) rdata_d = cache_or_data;
                end
            end
            FLUSH: begin
                flush_clr = 1'b1;
                fk_d      = fk_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        inst_ready     = (state_q == IDLE) && !fence_i;
        inst_valid     = (state_q == RESPOND);
        inst_data      = rdata_q;
        cache_read_ena = (state_q == REFILL);
        cache_addr     = '0;
        if (state_q == REFILL) cache_addr = line_base | (ADDR_W'(cnt_q) << 2);
        flush_done     = (state_q == FLUSH) && (fk_q == SI'(SETS - 1));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            fk_q     <= '0;
            victim_q <= '0;
            rdata_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            fk_q     <= fk_d;
            victim_q <= victim_d;
            rdata_q  <= rdata_d;
            if (fill_done) begin
                valid_q[set_idx][victim_q] <= 1'b1;
                rr_q[set_idx]              <= rr_next;
            end
            if (flush_clr) begin
                valid_q[fk_q] <= '0;
                rr_q[fk_q]    <= '0;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (wr_word)   data_q[victim_q][set_idx][cnt_q] <= cache_or_data;
        if (fill_done) tag_q[victim_q][set_idx]         <= tag_idx;
    end
endmodule
